alu_sequencer: RTL

- Issue-side controller for the CPU's 16-bit negedge ALU.
- Accepts one two-operand request (op, a, b) over a valid/ready handshake, then serialises it into the ALU's single-operand protocol:
  - load B with op 4'b1100;
  - execute with operand a;
  - capture r/nzcv and return them over a valid/ready response channel.
- Sits between decode/execute control and the ALU; it is the only driver of alu_a/alu_op.

---
 rtl/alu_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Issue-side controller for the 16-bit negedge ALU: takes one (op, a, b)
// request and serialises it into LOADB / EXEC steps, then returns r/nzcv.
module alu_sequencer #(
  parameter bit         SKIP_REDUNDANT_LOAD = 1'b1,
  parameter logic [3:0] IDLE_OP             = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_r,
  output logic [3:0]  resp_f,
  output logic [15:0] alu_a,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_r,
  input  logic [3:0]  alu_f
);

  localparam logic [3:0] OP_LOADB = 4'b1100;

  typedef enum logic [2:0] {IDLE, LOADB, EXEC, CAPT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  op_q;
  logic [15:0] a_q, b_q;
  logic [15:0] b_shadow;
  logic        b_shadow_valid;
  logic [15:0] alu_a_nxt;
  logic [3:0]  alu_op_nxt;
  logic [3:0]  src_op;
  logic [15:0] src_a, src_b;
  logic        b_needed;

  function automatic logic uses_b(input logic [3:0] op);
    case (op)
      4'b0001, 4'b0010, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1000: uses_b = 1'b1;
      default:                   uses_b = 1'b0;
    endcase
  endfunction

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  // Next-state and next ALU drive; operands come straight from the request
  // on the accept cycle and from the latched copy afterwards.
  always_comb begin
    state_nxt  = state;
    alu_a_nxt  = alu_a;
    alu_op_nxt = IDLE_OP;
    src_op     = (state == IDLE) ? req_op : op_q;
    src_a      = (state == IDLE) ? req_a  : a_q;
    src_b      = (state == IDLE) ? req_b  : b_q;
    b_needed   = uses_b(req_op) &&
                 !(SKIP_REDUNDANT_LOAD && b_shadow_valid && (req_b == b_shadow));
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_op == OP_LOADB || b_needed) state_nxt = LOADB;
          else                                state_nxt = EXEC;
        end
      end
      LOADB:   state_nxt = (op_q == OP_LOADB) ? RESP : EXEC;
      EXEC:    state_nxt = CAPT;
      CAPT:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == LOADB) begin
      alu_a_nxt  = src_b;
      alu_op_nxt = OP_LOADB;
    end else if (state_nxt == EXEC) begin
      alu_a_nxt  = src_a;
      alu_op_nxt = src_op;
    end
  end

  // State, registered ALU drive, request latch, B shadow and result capture.
  // The ALU result for EXEC is ready at the negedge inside EXEC, so it is
  // captured on the edge leaving EXEC, before IDLE_OP reaches the ALU.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      alu_a          <= '0;
      alu_op         <= IDLE_OP;
      resp_r         <= '0;
      resp_f         <= '0;
      b_shadow       <= '0;
      b_shadow_valid <= 1'b0;
      op_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
    end else begin
      state  <= state_nxt;
      alu_a  <= alu_a_nxt;
      alu_op <= alu_op_nxt;
      if (state == IDLE && req_valid) begin
        op_q <= req_op;
        a_q  <= req_a;
        b_q  <= req_b;
      end
      if (state == LOADB) begin
        b_shadow       <= b_q;
        b_shadow_valid <= 1'b1;
        if (op_q == OP_LOADB) begin
          resp_r <= b_q;
          resp_f <= '0;
        end
      end
      if (state == EXEC) begin
        resp_r <= alu_r;
        resp_f <= alu_f;
      end
    end
  end

endmodule
